// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences the shared ALU / unified memory / register file
// over several cycles per instruction, with a req/ack memory handshake and a retire counter.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      Op,
   input  logic             Zero,
   input  logic             mem_ack,
   output logic             PCWrite,
   output logic             PCSrc,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Reg2Loc,
   output logic             ALUSrc,
   output logic [1:0]       ALUOp,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EX_R, S_EX_MEM, S_EX_CBZ,
      S_MEM_RD, S_MEM_WR, S_WB_R, S_WB_LD, S_TRAP
   } state_t;

   state_t state, nxt;
   logic   retire;
   logic   is_ldur, is_stur, is_cbz, is_r;

   assign is_ldur = (Op == 11'b111_1100_0010);
   assign is_stur = (Op == 11'b111_1100_0000);
   assign is_cbz  = (Op[10:3] == 8'b1011_0100);
   assign is_r    = (Op == 11'b100_0101_1000) || (Op == 11'b110_0101_1000) ||
                    (Op == 11'b100_0101_0000) || (Op == 11'b101_0101_0000);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         state <= nxt;
         if (retire) retired <= retired + CNT_W'(1);
         // TRAP is only left through reset, so the flag stays set until then
         if (nxt == S_TRAP) illegal <= 1'b1;
      end
   end

   always_comb begin
      nxt      = state;
      retire   = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Reg2Loc  = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            if (mem_ack) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               nxt     = S_DECODE;
            end
         end
         S_DECODE: begin
            Reg2Loc = is_stur || is_cbz;
            if (is_r)                     nxt = S_EX_R;
            else if (is_ldur || is_stur)  nxt = S_EX_MEM;
            else if (is_cbz)              nxt = S_EX_CBZ;
            else                          nxt = S_TRAP;
         end
         S_EX_R: begin
            ALUOp = 2'b10;
            nxt   = S_WB_R;
         end
         S_EX_MEM: begin
            ALUSrc  = 1'b1;
            Reg2Loc = is_stur;
            if (is_ldur)      nxt = S_MEM_RD;
            else if (is_stur) nxt = S_MEM_WR;
            else              nxt = S_TRAP;
         end
         S_EX_CBZ: begin
            Reg2Loc = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 1'b1;
            PCWrite = Zero;
            retire  = 1'b1;
            nxt     = S_FETCH;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ack) nxt = S_WB_LD;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            Reg2Loc  = 1'b1;
            if (mem_ack) begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_WB_R: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            nxt      = S_FETCH;
         end
         S_WB_LD: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            retire   = 1'b1;
            nxt      = S_FETCH;
         end
         default: nxt = S_TRAP;
      endcase
      // controls are squelched combinationally while reset is held
      if (reset) begin
         PCWrite  = 1'b0;
         PCSrc    = 1'b0;
         IorD     = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         Reg2Loc  = 1'b0;
         ALUSrc   = 1'b0;
         ALUOp    = 2'b00;
         MemtoReg = 1'b0;
         RegWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-cycle controls,
// a negedge monitor pops and compares. Narrow counter to exercise wrap-around.
module tb_multicycle_ctrl;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset, Zero, mem_ack;
   logic [10:0]   Op;
   logic          PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite;
   logic          Reg2Loc, ALUSrc, MemtoReg, RegWrite, illegal;
   logic [1:0]    ALUOp;
   logic [CW-1:0] retired;

   multicycle_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ack(mem_ack),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD), .IRWrite(IRWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
      .ALUOp(ALUOp), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .illegal(illegal), .retired(retired)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCSrc,IorD,IRWrite,MemRead,MemWrite,Reg2Loc,ALUSrc,ALUOp,MemtoReg,RegWrite}
   localparam logic [11:0] NONE   = 12'b0_0_0_0_0_0_0_0_00_0_0;
   localparam logic [11:0] F_ACK  = 12'b1_0_0_1_1_0_0_0_00_0_0;
   localparam logic [11:0] F_WAIT = 12'b0_0_0_0_1_0_0_0_00_0_0;
   localparam logic [11:0] DEC_RL = 12'b0_0_0_0_0_0_1_0_00_0_0;
   localparam logic [11:0] EXR    = 12'b0_0_0_0_0_0_0_0_10_0_0;
   localparam logic [11:0] WBR    = 12'b0_0_0_0_0_0_0_0_00_0_1;
   localparam logic [11:0] EXM_LD = 12'b0_0_0_0_0_0_0_1_00_0_0;
   localparam logic [11:0] EXM_ST = 12'b0_0_0_0_0_0_1_1_00_0_0;
   localparam logic [11:0] MRD    = 12'b0_0_1_0_1_0_0_0_00_0_0;
   localparam logic [11:0] MWR    = 12'b0_0_1_0_0_1_1_0_00_0_0;
   localparam logic [11:0] WBLD   = 12'b0_0_0_0_0_0_0_0_00_1_1;
   localparam logic [11:0] CBZ_T  = 12'b1_1_0_0_0_0_1_0_01_0_0;
   localparam logic [11:0] CBZ_N  = 12'b0_1_0_0_0_0_1_0_01_0_0;

   localparam logic [10:0] OP_ADD  = 11'b100_0101_1000;
   localparam logic [10:0] OP_SUB  = 11'b110_0101_1000;
   localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
   localparam logic [10:0] OP_CBZ5 = 11'b101_1010_0101;
   localparam logic [10:0] OP_CBZ0 = 11'b101_1010_0000;
   localparam logic [10:0] OP_BAD  = 11'b000_0000_0000;

   typedef struct {
      logic [11:0]   ctrl;
      logic          ill;
      logic [CW-1:0] ret;
      string         nm;
   } exp_t;

   exp_t          q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] ret;
   bit            done = 1'b0;

   task automatic cyc(input logic r, input logic [10:0] op, input logic z, input logic ack,
                      input logic [11:0] c, input logic il, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset = r; Op = op; Zero = z; mem_ack = ack;
      e.ctrl = c; e.ill = il; e.ret = ret; e.nm = nm;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [11:0] act;
         e   = q.pop_front();
         act = {PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, Reg2Loc, ALUSrc,
                ALUOp, MemtoReg, RegWrite};
         n_cmp = n_cmp + 3;
         if (act !== e.ctrl) begin
            n_bad++;
            $display("FAIL %s ctrl: got %b want %b", e.nm, act, e.ctrl);
         end
         if (illegal !== e.ill) begin
            n_bad++;
            $display("FAIL %s illegal: got %b want %b", e.nm, illegal, e.ill);
         end
         if (retired !== e.ret) begin
            n_bad++;
            $display("FAIL %s retired: got %0d want %0d", e.nm, retired, e.ret);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; Op = OP_BAD; Zero = 1'b0; mem_ack = 1'b0; ret = '0;
      @(posedge clk);
      cyc(1, OP_BAD, 0, 0, NONE, 0, "rst0");
      cyc(1, OP_BAD, 0, 1, NONE, 0, "rst1");
      // ADD then SUB, ack tied high
      cyc(0, OP_ADD, 0, 1, F_ACK, 0, "add_fetch");
      cyc(0, OP_ADD, 0, 1, NONE,  0, "add_dec");
      cyc(0, OP_ADD, 0, 1, EXR,   0, "add_exr");
      cyc(0, OP_ADD, 0, 1, WBR,   0, "add_wb");
      ret++;
      cyc(0, OP_SUB, 0, 1, F_ACK, 0, "sub_fetch");
      cyc(0, OP_SUB, 0, 1, NONE,  0, "sub_dec");
      cyc(0, OP_SUB, 0, 1, EXR,   0, "sub_exr");
      cyc(0, OP_SUB, 0, 1, WBR,   0, "sub_wb");
      ret++;
      // LDUR with three wait cycles in MEM_RD
      cyc(0, OP_LDUR, 0, 1, F_ACK,  0, "ld_fetch");
      cyc(0, OP_LDUR, 0, 1, NONE,   0, "ld_dec");
      cyc(0, OP_LDUR, 0, 1, EXM_LD, 0, "ld_exm");
      cyc(0, OP_LDUR, 0, 0, MRD,    0, "ld_mrd_w0");
      cyc(0, OP_LDUR, 0, 0, MRD,    0, "ld_mrd_w1");
      cyc(0, OP_LDUR, 0, 0, MRD,    0, "ld_mrd_w2");
      cyc(0, OP_LDUR, 0, 1, MRD,    0, "ld_mrd_ack");
      cyc(0, OP_LDUR, 0, 1, WBLD,   0, "ld_wb");
      ret++;
      // STUR with a fetch wait and a write wait; counter wraps 3 -> 0
      cyc(0, OP_STUR, 0, 0, F_WAIT, 0, "st_fetch_w");
      cyc(0, OP_STUR, 0, 1, F_ACK,  0, "st_fetch");
      cyc(0, OP_STUR, 0, 1, DEC_RL, 0, "st_dec");
      cyc(0, OP_STUR, 0, 1, EXM_ST, 0, "st_exm");
      cyc(0, OP_STUR, 0, 0, MWR,    0, "st_mwr_w");
      cyc(0, OP_STUR, 0, 1, MWR,    0, "st_mwr_ack");
      ret++;
      // CBZ taken then not taken
      cyc(0, OP_CBZ5, 1, 1, F_ACK,  0, "cbz1_fetch");
      cyc(0, OP_CBZ5, 1, 1, DEC_RL, 0, "cbz1_dec");
      cyc(0, OP_CBZ5, 1, 1, CBZ_T,  0, "cbz1_ex");
      ret++;
      cyc(0, OP_CBZ0, 0, 1, F_ACK,  0, "cbz0_fetch");
      cyc(0, OP_CBZ0, 0, 1, DEC_RL, 0, "cbz0_dec");
      cyc(0, OP_CBZ0, 0, 1, CBZ_N,  0, "cbz0_ex");
      ret++;
      // reset while waiting in MEM_RD
      cyc(0, OP_LDUR, 0, 1, F_ACK,  0, "ldr_fetch");
      cyc(0, OP_LDUR, 0, 1, NONE,   0, "ldr_dec");
      cyc(0, OP_LDUR, 0, 1, EXM_LD, 0, "ldr_exm");
      cyc(0, OP_LDUR, 0, 0, MRD,    0, "ldr_mrd");
      cyc(1, OP_LDUR, 0, 0, NONE,   0, "ldr_rst0");
      ret = '0;
      cyc(1, OP_LDUR, 0, 0, NONE,   0, "ldr_rst1");
      cyc(0, OP_ADD,  0, 0, F_WAIT, 0, "post_rst_fetch");
      cyc(0, OP_ADD,  0, 1, F_ACK,  0, "add2_fetch");
      cyc(0, OP_ADD,  0, 1, NONE,   0, "add2_dec");
      cyc(0, OP_ADD,  0, 1, EXR,    0, "add2_exr");
      cyc(0, OP_ADD,  0, 1, WBR,    0, "add2_wb");
      ret++;
      // illegal opcode traps, outputs stay low, counter frozen
      cyc(0, OP_BAD, 1, 1, F_ACK, 0, "bad_fetch");
      cyc(0, OP_BAD, 1, 1, NONE,  0, "bad_dec");
      cyc(0, OP_BAD, 1, 1, NONE,  1, "trap0");
      cyc(0, OP_ADD, 1, 1, NONE,  1, "trap1");
      cyc(0, OP_LDUR, 1, 1, NONE, 1, "trap2");
      cyc(1, OP_BAD, 0, 1, NONE,  1, "trap_rst");
      ret = '0;
      cyc(0, OP_ADD, 0, 1, F_ACK, 0, "after_trap");
      @(posedge clk);
      @(posedge clk);
      done = 1'b1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the LEGv8 core. It sequences a shared datapath (one ALU, one unified instruction/data memory port, register file) over several clock cycles per instruction. It supports the same instruction subset as the single-cycle decoder: LDUR, STUR, CBZ, ADD, SUB, AND and ORR. Memory accesses use a request/acknowledge handshake, and the block counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- Op  input  11  opcode field Instr[31:21] from the instruction register; stable from DECODE until the next FETCH
- Zero  input  1  ALU zero flag, valid in the CBZ execute cycle
- mem_ack  input  1  memory completes the current MemRead/MemWrite this cycle
- PCWrite  output  1  load PC this cycle
- PCSrc  output  1  0 = PC+4, 1 = branch target
- IorD  output  1  memory address source: 0 = PC, 1 = ALU result
- IRWrite  output  1  load instruction register
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- Reg2Loc  output  1  1 = second read register from Rt (Instr[4:0])
- ALUSrc  output  1  1 = sign-extended immediate as ALU operand B
- ALUOp  output  2  00 add, 01 pass-B/compare, 10 use funct (R-type)
- MemtoReg  output  1  1 = write-back data from memory data register
- RegWrite  output  1  register file write enable
- illegal  output  1  sticky; unknown opcode decoded
- retired  output  CNT_W  count of completed instructions

## Operation
- Opcode classes, all exact matches except CBZ:
  - LDUR: 111_1100_0010
  - STUR: 111_1100_0000
  - CBZ: 101_1010_0??? (low 3 bits don't-care)
  - R-type: ADD 100_0101_1000, SUB 110_0101_1000, AND 100_0101_0000, ORR 101_0101_0000
- State encoding is free. States and outputs (any output not listed is 0):
  - FETCH: MemRead=1, IorD=0. If mem_ack: IRWrite=1, PCWrite=1, PCSrc=0, next DECODE; else stay.
  - DECODE: Reg2Loc=1 for STUR/CBZ, else 0. Next by class: R-type→EX_R, LDUR/STUR→EX_MEM, CBZ→EX_CBZ, other→TRAP.
  - EX_R: ALUSrc=0, ALUOp=10. Next WB_R.
  - EX_MEM: ALUSrc=1, ALUOp=00, Reg2Loc as in DECODE. Next MEM_RD for LDUR, MEM_WR for STUR.
  - EX_CBZ: Reg2Loc=1, ALUOp=01, PCSrc=1, PCWrite=Zero. Next FETCH; retire.
  - MEM_RD: MemRead=1, IorD=1. Stays until mem_ack, then WB_LD.
  - MEM_WR: MemWrite=1, IorD=1, Reg2Loc=1. Stays until mem_ack, then FETCH; retire.
  - WB_R: RegWrite=1, MemtoReg=0. Next FETCH; retire.
  - WB_LD: RegWrite=1, MemtoReg=1. Next FETCH; retire.
  - TRAP: all control outputs 0, illegal=1. Only reset leaves TRAP.
- A retire increments `retired` by 1 on that clock edge. The counter wraps from all-ones to 0.
- MemRead and MemWrite are never 1 in the same cycle. RegWrite and MemWrite are never 1 in the same cycle.

## Timing
- Reset: on a rising edge with reset=1, the block goes to FETCH, clears `retired` to 0 and clears `illegal` to 0. This applies in any state, including mid-wait in MEM_RD/MEM_WR and in TRAP.
- While reset=1, all control outputs are combinationally forced to 0. After reset deasserts, the first cycle is FETCH with MemRead=1.
- Control outputs are combinational from state, with Op affecting DECODE/EX_MEM and Zero affecting EX_CBZ. `illegal` and `retired` are registered.
- Handshake: a request holds steady, with address source unchanged, until the cycle mem_ack=1. That cycle completes the transfer and the state advances on the next edge. mem_ack is ignored in states that make no request.
- Cycles per instruction, with mem_ack already high on request:
  - R-type: 4
  - LDUR: 5
  - STUR: 4
  - CBZ: 3
- Each cycle of mem_ack low adds one cycle per memory access.

## Test plan
- Reset: assert reset 2 cycles in MEM_RD with mem_ack=0 → all outputs 0 during reset, `retired`=0; after release, FETCH with MemRead=1, IorD=0.
- ADD then SUB, mem_ack tied 1: Op=100_0101_1000 → EX_R shows ALUOp=10 and WB_R shows RegWrite=1. Then Op=110_0101_1000 → `retired`=2 after 8 cycles.
- LDUR with mem_ack low for 3 cycles in MEM_RD → MemRead=1, IorD=1 held 4 cycles; WB_LD shows MemtoReg=1, RegWrite=1; total 8 cycles.
- STUR: Op=111_1100_0000 → Reg2Loc=1 in DECODE, ALUSrc=1 in EX_MEM, MemWrite=1 with RegWrite=0; `retired`+1 on ack.
- CBZ: Op=101_1010_0101 with Zero=1 → PCWrite=1, PCSrc=1 in cycle 3. With Zero=0 → PCWrite=0 in EX_CBZ; both retire.
- Illegal: Op=000_0000_0000 → TRAP, `illegal`=1 from the next cycle, all controls 0 indefinitely, `retired` unchanged; reset clears `illegal`.
